scb_multi_pip: RTL and testbench



---
 rtl/scb_multi_pip.sv | 145 ++++++++++++++
 tb/tb_scb_multi_pip.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scb_multi_pip.sv
// scb_multi_pip: issue/writeback scoreboard for N_PIP fixed-latency pipes.
// Tracks in-flight ops in S_AMT_CELL cells, refuses issues that would collide
// on the single writeback port, and reports pending destinations/occupancy.
//
// Handshake: CDI_PD_vld[p] is a request offer from pipe p's reservation
// station; CDO_PC_selrsv is the one-hot grant for the same cycle. A request
// is consumed at the rising edge only when its grant bit is high; otherwise
// the requester must keep (or withdraw) it -- nothing is buffered here.
module scb_multi_pip #(
  parameter int unsigned W_PA_REG   = 5,
  parameter int unsigned N_PIP      = 2,
  parameter int unsigned W_PIP_IDX  = 1,
  parameter int unsigned S_AMT_CELL = 8,
  parameter int unsigned W_IDENT    = 3,
  parameter int unsigned W_STATE    = 3,
  parameter logic [N_PIP*W_STATE-1:0] V_LAT = {3'd4, 3'd1}
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          CFI_PC_clear,
  input  logic [N_PIP-1:0]              CDI_PD_vld,
  input  logic [N_PIP*W_PA_REG-1:0]     CDI_PD_rd,
  input  logic [W_PIP_IDX-1:0]          CDI_PC_odr,
  output logic [N_PIP-1:0]              CDO_PC_selrsv,
  output logic                          CDO_PC_wbvld,
  output logic [W_PA_REG-1:0]           CDO_PC_rd,
  output logic [N_PIP-1:0]              CDO_PC_selwb,
  output logic [(1<<W_PA_REG)-1:0]      CDO_PC_busy,
  output logic                          CDO_PC_full,
  output logic [W_IDENT:0]              CDO_PC_occ
);

  // Cell storage
  logic                 cell_vld_q [S_AMT_CELL];
  logic [W_PIP_IDX-1:0] cell_pip_q [S_AMT_CELL];
  logic [W_PA_REG-1:0]  cell_rd_q  [S_AMT_CELL];
  logic [W_STATE-1:0]   cell_s_q   [S_AMT_CELL];

  logic                         ins_any;
  logic [W_IDENT-1:0]           ins_idx;
  logic                         ret_any;
  logic [W_IDENT-1:0]           ret_idx;
  logic [N_PIP-1:0]             hazard;
  logic [N_PIP-1:0]             elig;
  logic [(1<<W_PA_REG)-1:0]     busy;
  logic [W_IDENT:0]             occ;
  logic                         sel_any;
  logic [W_PIP_IDX-1:0]         sel_pip;
  logic [W_PA_REG-1:0]          sel_rd;
  logic [W_STATE-1:0]           sel_lat;
  logic [N_PIP-1:0]             selrsv;
  int                           pi;

  // Cell scan: lowest insertable cell, retiring cell, hazards, busy map, occupancy
  always_comb begin
    ins_any = 1'b0;
    ins_idx = '0;
    ret_any = 1'b0;
    ret_idx = '0;
    hazard  = '0;
    busy    = '0;
    occ     = '0;
    // Descending scan so the last hit is the lowest index
    for (int i = S_AMT_CELL - 1; i >= 0; i--) begin
      if (!cell_vld_q[i] || cell_s_q[i] == '0) begin
        ins_any = 1'b1;
        ins_idx = W_IDENT'(i);
      end
      if (cell_vld_q[i] && cell_s_q[i] == '0) begin
        ret_any = 1'b1;
        ret_idx = W_IDENT'(i);
      end
      if (cell_vld_q[i]) begin
        busy[cell_rd_q[i]] = 1'b1;
        occ = occ + (W_IDENT+1)'(1);
      end
      // A cell with s == LAT_p would retire in the same cycle as a new pipe-p entry
      for (int p = 0; p < N_PIP; p++) begin
        if (cell_vld_q[i] && cell_s_q[i] == V_LAT[p*W_STATE +: W_STATE]) hazard[p] = 1'b1;
      end
    end
  end

  assign elig = CDI_PD_vld & ~hazard & {N_PIP{ins_any && !CFI_PC_clear && !rst}};

  // Rotating-priority pick starting at CDI_PC_odr
  always_comb begin
    sel_any = 1'b0;
    sel_pip = '0;
    sel_rd  = '0;
    sel_lat = '0;
    pi      = 0;
    for (int k = 0; k < N_PIP; k++) begin
      pi = (int'(CDI_PC_odr) + k) % N_PIP;
      if (!sel_any && elig[pi]) begin
        sel_any = 1'b1;
        sel_pip = W_PIP_IDX'(pi);
        sel_rd  = CDI_PD_rd[pi*W_PA_REG +: W_PA_REG];
        sel_lat = V_LAT[pi*W_STATE +: W_STATE];
      end
    end
    selrsv = sel_any ? (N_PIP'(1) << sel_pip) : '0;
  end

  // Writeback and status outputs from registered state
  always_comb begin
    CDO_PC_wbvld = ret_any;
    CDO_PC_rd    = ret_any ? cell_rd_q[ret_idx] : '0;
    CDO_PC_selwb = ret_any ? (N_PIP'(1) << cell_pip_q[ret_idx]) : '0;
  end

  assign CDO_PC_selrsv = selrsv;
  assign CDO_PC_busy   = busy;
  assign CDO_PC_full   = !ins_any;
  assign CDO_PC_occ    = occ;

  // Cell update: flush, countdown/retire, then insert (insert may reuse the retiring cell)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < S_AMT_CELL; i++) begin
        cell_vld_q[i] <= 1'b0;
        cell_pip_q[i] <= '0;
        cell_rd_q[i]  <= '0;
        cell_s_q[i]   <= '0;
      end
    end else if (CFI_PC_clear) begin
      for (int i = 0; i < S_AMT_CELL; i++) begin
        cell_vld_q[i] <= 1'b0;
        cell_s_q[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < S_AMT_CELL; i++) begin
        if (cell_vld_q[i] && cell_s_q[i] != '0) cell_s_q[i] <= cell_s_q[i] - 1'b1;
        else if (cell_vld_q[i]) cell_vld_q[i] <= 1'b0;
      end
      if (sel_any) begin
        cell_vld_q[ins_idx] <= 1'b1;
        cell_pip_q[ins_idx] <= sel_pip;
        cell_rd_q[ins_idx]  <= sel_rd;
        cell_s_q[ins_idx]   <= sel_lat - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_scb_multi_pip.sv
// Bench for scb_multi_pip: directed scenarios plus randomized traffic checked
// against a queue-of-entries model (each entry knows its absolute writeback cycle).
module tb_scb_multi_pip;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- instance A: default parameters ----------------
  logic        a_clear;
  logic [1:0]  a_vld;
  logic [9:0]  a_rd;
  logic        a_odr;
  logic [1:0]  a_sel;
  logic        a_wbvld;
  logic [4:0]  a_wbrd;
  logic [1:0]  a_selwb;
  logic [31:0] a_busy;
  logic        a_full;
  logic [3:0]  a_occ;

  scb_multi_pip dut_a (
    .clk(clk), .rst(rst), .CFI_PC_clear(a_clear),
    .CDI_PD_vld(a_vld), .CDI_PD_rd(a_rd), .CDI_PC_odr(a_odr),
    .CDO_PC_selrsv(a_sel), .CDO_PC_wbvld(a_wbvld), .CDO_PC_rd(a_wbrd),
    .CDO_PC_selwb(a_selwb), .CDO_PC_busy(a_busy), .CDO_PC_full(a_full),
    .CDO_PC_occ(a_occ)
  );

  // ---------------- instance B: 4 cells, pipe1 latency 7 ----------------
  logic        b_clear;
  logic [1:0]  b_vld;
  logic [9:0]  b_rd;
  logic        b_odr;
  logic [1:0]  b_sel;
  logic        b_wbvld;
  logic [4:0]  b_wbrd;
  logic [1:0]  b_selwb;
  logic [31:0] b_busy;
  logic        b_full;
  logic [2:0]  b_occ;

  scb_multi_pip #(.S_AMT_CELL(4), .W_IDENT(2), .V_LAT({3'd7, 3'd1})) dut_b (
    .clk(clk), .rst(rst), .CFI_PC_clear(b_clear),
    .CDI_PD_vld(b_vld), .CDI_PD_rd(b_rd), .CDI_PC_odr(b_odr),
    .CDO_PC_selrsv(b_sel), .CDO_PC_wbvld(b_wbvld), .CDO_PC_rd(b_wbrd),
    .CDO_PC_selwb(b_selwb), .CDO_PC_busy(b_busy), .CDO_PC_full(b_full),
    .CDO_PC_occ(b_occ)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- reference model for instance A ----------------
  typedef struct {int pipe; int rd; int wb;} ent_t;
  ent_t mq[$];
  int   now = 0;
  int   lat_a [2] = '{1, 4};
  int   e_pipe;
  logic [1:0]  e_sel;
  logic        e_wbvld;
  logic [4:0]  e_rd;
  logic [1:0]  e_selwb;
  logic [31:0] e_busy;
  logic        e_full;
  logic [3:0]  e_occ;

  function automatic void model_eval();
    bit room;
    bit haz;
    int p;
    e_occ = 4'(mq.size());
    e_busy = '0; e_wbvld = 1'b0; e_rd = '0; e_selwb = '0;
    room = (mq.size() < 8);
    foreach (mq[i]) begin
      e_busy[mq[i].rd] = 1'b1;
      if (mq[i].wb == now) begin
        e_wbvld = 1'b1; e_rd = 5'(mq[i].rd); e_selwb = 2'(1 << mq[i].pipe); room = 1'b1;
      end
    end
    e_full = !room;
    e_pipe = -1;
    if (!rst && !a_clear && room) begin
      for (int k = 0; k < 2; k++) begin
        p = (int'(a_odr) + k) % 2;
        haz = 1'b0;
        foreach (mq[i]) if (mq[i].wb - now == lat_a[p]) haz = 1'b1;
        if (e_pipe < 0 && a_vld[p] && !haz) e_pipe = p;
      end
    end
    e_sel = (e_pipe >= 0) ? 2'(1 << e_pipe) : 2'b00;
  endfunction

  function automatic void model_advance();
    if (rst || a_clear) begin
      mq.delete();
    end else begin
      for (int i = mq.size() - 1; i >= 0; i--) if (mq[i].wb == now) mq.delete(i);
      if (e_pipe >= 0) mq.push_back('{e_pipe, int'(a_rd[e_pipe*5 +: 5]), now + lat_a[e_pipe]});
    end
    now++;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    model_eval();
    @(posedge clk);
    model_advance();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    a_clear = 0; a_vld = 0; a_rd = 0; a_odr = 0;
    b_clear = 0; b_vld = 0; b_rd = 0; b_odr = 0;
    @(negedge clk);
    checks++; if ({a_sel, a_wbvld, a_wbrd, a_selwb, a_busy, a_full, a_occ} !== '0) begin
      errors++; $display("FAIL reset_a got sel=%b wb=%b rd=%0d selwb=%b busy=%h full=%b occ=%0d want all 0",
        a_sel, a_wbvld, a_wbrd, a_selwb, a_busy, a_full, a_occ); end
    checks++; if ({b_sel, b_wbvld, b_busy, b_full, b_occ} !== '0) begin
      errors++; $display("FAIL reset_b got sel=%b wb=%b busy=%h full=%b occ=%0d want all 0",
        b_sel, b_wbvld, b_busy, b_full, b_occ); end
    rst = 1'b0;
    mq.delete();
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    a_vld = 2'b01; a_rd[4:0] = 5'd7; a_odr = 1'b0;
    @(negedge clk);
    checks++; if (a_sel !== 2'b01) begin errors++; $display("FAIL basic_sel got %b want 01", a_sel); end
    step();
    a_vld = 2'b00;
    @(negedge clk);
    checks++; if ({a_wbvld, a_wbrd, a_selwb} !== {1'b1, 5'd7, 2'b01}) begin
      errors++; $display("FAIL basic_wb got %b/%0d/%b want 1/7/01", a_wbvld, a_wbrd, a_selwb); end
    checks++; if (a_busy !== 32'h80) begin errors++; $display("FAIL basic_busy got %h want 00000080", a_busy); end
    step();
    @(negedge clk);
    checks++; if ({a_wbvld, a_busy, a_occ} !== '0) begin
      errors++; $display("FAIL basic_idle got wb=%b busy=%h occ=%0d want 0", a_wbvld, a_busy, a_occ); end
    step();
  endtask

  task automatic test_hazard();
    logic [1:0] want_sel [4] = '{2'b10, 2'b01, 2'b01, 2'b00};
    a_vld = 2'b11; a_rd = {5'd3, 5'd4}; a_odr = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (c == 1) begin a_vld = 2'b01; a_odr = 1'b0; end
      if (c == 4) a_vld = 2'b00;
      @(negedge clk);
      if (c < 4) begin
        checks++; if (a_sel !== want_sel[c]) begin
          errors++; $display("FAIL hazard_sel c%0d got %b want %b", c, a_sel, want_sel[c]); end
      end
      if (c == 2 || c == 3) begin
        checks++; if ({a_wbvld, a_wbrd, a_selwb} !== {1'b1, 5'd4, 2'b01}) begin
          errors++; $display("FAIL hazard_wb4 c%0d got %b/%0d/%b want 1/4/01", c, a_wbvld, a_wbrd, a_selwb); end
      end
      if (c == 4) begin
        checks++; if ({a_wbvld, a_wbrd, a_selwb} !== {1'b1, 5'd3, 2'b10}) begin
          errors++; $display("FAIL hazard_wb3 got %b/%0d/%b want 1/3/10", a_wbvld, a_wbrd, a_selwb); end
      end
      if (c == 5) begin
        checks++; if ({a_wbvld, a_occ} !== '0) begin
          errors++; $display("FAIL hazard_drain got wb=%b occ=%0d want 0/0", a_wbvld, a_occ); end
      end
      step();
    end
  endtask

  task automatic test_priority();
    a_vld = 2'b11; a_rd = {5'd1, 5'd2}; a_odr = 1'b1;
    @(negedge clk);
    checks++; if (a_sel !== 2'b10) begin errors++; $display("FAIL prio_odr1 got %b want 10", a_sel); end
    a_odr = 1'b0;
    #1;
    checks++; if (a_sel !== 2'b01) begin errors++; $display("FAIL prio_odr0 got %b want 01", a_sel); end
    a_vld = 2'b00;
    step();
  endtask

  task automatic test_clear();
    a_vld = 2'b10; a_odr = 1'b0;
    for (int c = 0; c < 3; c++) begin a_rd[9:5] = 5'(10 + c); step(); end
    a_vld = 2'b00; step();
    a_vld = 2'b01; a_rd[4:0] = 5'd20; a_clear = 1'b1;
    @(negedge clk);
    checks++; if (a_sel !== 2'b00) begin errors++; $display("FAIL clear_sel got %b want 00", a_sel); end
    checks++; if ({a_wbvld, a_wbrd, a_selwb, a_occ} !== {1'b1, 5'd10, 2'b10, 4'd3}) begin
      errors++; $display("FAIL clear_wb got %b/%0d/%b occ=%0d want 1/10/10 occ=3", a_wbvld, a_wbrd, a_selwb, a_occ); end
    step();
    a_clear = 1'b0; a_vld = 2'b00;
    @(negedge clk);
    checks++; if ({a_occ, a_busy, a_wbvld} !== '0) begin
      errors++; $display("FAIL clear_after got occ=%0d busy=%h wb=%b want 0", a_occ, a_busy, a_wbvld); end
    step();
  endtask

  task automatic test_full_reuse();
    logic [2:0] w_occ;
    logic       w_full;
    logic [1:0] w_sel;
    logic [7:0] w_wb;
    a_odr = 1'b0; b_odr = 1'b0;
    for (int k = 0; k < 9; k++) begin
      a_vld = 2'b10; a_rd[9:5] = 5'($urandom_range(0, 31));
      b_vld = 2'b10; b_rd[9:5] = 5'(k);
      @(negedge clk);
      checks++; if ({a_sel, a_full, a_occ} !== {2'b10, 1'b0, 4'((k < 4) ? k : 4)}) begin
        errors++; $display("FAIL full_a k%0d got sel=%b full=%b occ=%0d want 10/0/%0d", k, a_sel, a_full, a_occ, (k < 4) ? k : 4); end
      w_occ  = 3'((k < 4) ? k : 4);
      w_full = (k >= 4 && k <= 6);
      w_sel  = (k <= 3 || k >= 7) ? 2'b10 : 2'b00;
      w_wb   = (k == 7) ? {1'b1, 5'd0, 2'b10} : (k == 8) ? {1'b1, 5'd1, 2'b10} : 8'd0;
      checks++; if ({b_sel, b_full, b_occ} !== {w_sel, w_full, w_occ}) begin
        errors++; $display("FAIL full_b k%0d got sel=%b full=%b occ=%0d want %b/%b/%0d", k, b_sel, b_full, b_occ, w_sel, w_full, w_occ); end
      checks++; if ({b_wbvld, b_wbrd, b_selwb} !== w_wb) begin
        errors++; $display("FAIL full_b_wb k%0d got %b/%0d/%b want %b", k, b_wbvld, b_wbrd, b_selwb, w_wb); end
      step();
    end
    a_vld = 2'b00; b_vld = 2'b00;
  endtask

  task automatic test_async_reset();
    a_vld = 2'b10; a_odr = 1'b0;
    a_rd[9:5] = 5'd9; step();
    a_rd[9:5] = 5'd10; step();
    a_vld = 2'b01; a_rd[4:0] = 5'd5;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++; if ({a_sel, a_wbvld, a_wbrd, a_selwb, a_busy, a_full, a_occ} !== '0) begin
      errors++; $display("FAIL arst_a got sel=%b wb=%b rd=%0d selwb=%b busy=%h full=%b occ=%0d want all 0",
        a_sel, a_wbvld, a_wbrd, a_selwb, a_busy, a_full, a_occ); end
    checks++; if ({b_busy, b_occ, b_wbvld} !== '0) begin
      errors++; $display("FAIL arst_b got busy=%h occ=%0d wb=%b want 0", b_busy, b_occ, b_wbvld); end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    mq.delete();
    #1;
    checks++; if (a_sel !== 2'b01) begin errors++; $display("FAIL arst_first_accept got %b want 01", a_sel); end
    step();
    a_vld = 2'b00;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      checks++; if ({a_wbvld, a_wbrd} !== ((c == 0) ? {1'b1, 5'd5} : 6'd0)) begin
        errors++; $display("FAIL arst_wb c%0d got %b/%0d want %0d", c, a_wbvld, a_wbrd, (c == 0) ? 5 : 0); end
      step();
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      a_vld   = 2'($urandom_range(0, 3));
      a_rd    = 10'($urandom);
      a_odr   = 1'($urandom_range(0, 1));
      a_clear = ($urandom_range(0, 15) == 0);
      @(negedge clk);
      model_eval();
      checks++; if ({a_sel, a_wbvld, a_wbrd, a_selwb, a_full, a_occ} !== {e_sel, e_wbvld, e_rd, e_selwb, e_full, e_occ}) begin
        errors++; $display("FAIL rand_out c%0d got sel=%b wb=%b rd=%0d selwb=%b full=%b occ=%0d want sel=%b wb=%b rd=%0d selwb=%b full=%b occ=%0d",
          c, a_sel, a_wbvld, a_wbrd, a_selwb, a_full, a_occ, e_sel, e_wbvld, e_rd, e_selwb, e_full, e_occ); end
      checks++; if (a_busy !== e_busy) begin
        errors++; $display("FAIL rand_busy c%0d got %h want %h", c, a_busy, e_busy); end
      step();
    end
    a_vld = 2'b00; a_clear = 1'b0;
  endtask

  // ---------------- sequence and final report ----------------
  initial begin
    test_reset();
    test_basic();
    test_hazard();
    test_priority();
    test_clear();
    test_full_reuse();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
